// File: rtl/cic_pkg.sv
// Shared CIC definitions: scheduler states and default datapath
// widths/rates used by the scheduler and the CIC datapath.
package cic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } cic_state_e;

  localparam int CIC_NCH      = 4;
  localparam int CIC_SAMPLE_W = 16;
  localparam int CIC_DEF_RATE = 4;
  localparam int CIC_RATE_W   = 8;

endpackage

// File: rtl/cic_rr_arbiter.sv
// Round-robin pick: first set bit of req scanning cyclically from ptr.
// Ports: req/ptr in; gnt (one-hot), idx, any out. Purely combinational.
module cic_rr_arbiter #(
  parameter  int NCH = 4,
  localparam int CW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [CW-1:0]  idx,
  output logic           any
);

  int c;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int i = 0; i < NCH; i++) begin
      c = (int'(ptr) + i) % NCH;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = CW'(c);
      end
    end
  end

endmodule

// File: rtl/cic_channel_scheduler.sv
// Shares one CIC datapath among NCH channels: round-robin issue, per-channel
// decimation phase / dump flag, run-time rate, start/stop/zero-flush FSM.
// Ports: clk/rst; cfg_rate/cfg_load/start/stop control; in_valid/in_data/
// in_ready channel streams; dp_* registered issue port; rate_q, busy, cfg_err.
module cic_channel_scheduler
  import cic_pkg::*;
#(
  parameter  int NCH = CIC_NCH,
  parameter  int M   = CIC_SAMPLE_W,
  parameter  int R   = CIC_DEF_RATE,
  parameter  int RW  = CIC_RATE_W,
  localparam int CW  = $clog2(NCH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [RW-1:0]  cfg_rate,
  input  logic           cfg_load,
  input  logic           start,
  input  logic           stop,
  input  logic [NCH-1:0] in_valid,
  input  logic [NCH*M-1:0] in_data,
  output logic [NCH-1:0] in_ready,
  output logic           dp_valid,
  output logic [CW-1:0]  dp_chan,
  output logic [M-1:0]   dp_data,
  output logic           dp_dump,
  input  logic           dp_ready,
  output logic [RW-1:0]  rate_q,
  output logic           busy,
  output logic           cfg_err
);

  cic_state_e state, state_nx;

  logic [RW-1:0]  phase [NCH];
  logic [CW-1:0]  rr_ptr;
  logic [NCH-1:0] phase_nz;
  logic [NCH-1:0] req;
  logic [NCH-1:0] gnt;
  logic [CW-1:0]  gnt_idx;
  logic           gnt_any;
  logic           slot_free;
  logic           issue;
  logic           dump;
  logic [RW-1:0]  cur_phase;
  logic [M-1:0]   issue_data;

  always_comb begin
    phase_nz = '0;
    for (int c = 0; c < NCH; c++) begin
      phase_nz[c] = |phase[c];
    end
  end

  // RUN arbitrates live traffic; FLUSH arbitrates channels left
  // mid-frame so their partial frames get zero-padded out.
  always_comb begin
    req = '0;
    unique case (state)
      RUN:     req = in_valid;
      FLUSH:   req = phase_nz;
      default: req = '0;
    endcase
  end

  cic_rr_arbiter #(
    .NCH (NCH)
  ) u_arb (
    .req (req),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign slot_free = !dp_valid || dp_ready;
  assign issue     = slot_free && gnt_any;
  assign cur_phase = phase[gnt_idx];
  assign dump      = (cur_phase == rate_q - RW'(1));
  assign in_ready  = (state == RUN && slot_free) ? gnt : '0;
  assign busy      = (state != IDLE);

  always_comb begin
    issue_data = '0;
    if (state == RUN) begin
      issue_data = in_data[int'(gnt_idx)*M +: M];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = RUN;
      RUN:   if (stop)  state_nx = FLUSH;
      FLUSH: if (phase_nz == '0 && slot_free)
               state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dp_valid <= 1'b0;
      dp_chan  <= '0;
      dp_data  <= '0;
      dp_dump  <= 1'b0;
      rr_ptr   <= '0;
      rate_q   <= RW'(R);
      cfg_err  <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        phase[c] <= '0;
      end
    end else begin
      cfg_err <= cfg_load &&
                 (state != IDLE || cfg_rate == '0);
      if (cfg_load && state == IDLE && cfg_rate != '0) begin
        rate_q <= cfg_rate;
      end
      if (slot_free) begin
        dp_valid <= issue;
        if (issue) begin
          dp_chan <= gnt_idx;
          dp_data <= issue_data;
          dp_dump <= dump;
        end
      end
      if (issue) begin
        phase[gnt_idx] <= dump ? '0 : cur_phase + RW'(1);
        rr_ptr <= (gnt_idx == CW'(NCH-1)) ? '0
                : gnt_idx + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_cic_channel_scheduler.sv
// Directed bench for cic_channel_scheduler: arbitration order, stalls,
// dump timing, flush, config errors, rate 1 and mid-flush reset.
module tb_cic_channel_scheduler;

  localparam int NCH = 4;
  localparam int M   = 16;
  localparam int RW  = 8;
  localparam int CW  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [RW-1:0]  cfg_rate;
  logic           cfg_load;
  logic           start;
  logic           stop;
  logic [NCH-1:0] in_valid;
  logic [NCH*M-1:0] in_data;
  logic [NCH-1:0] in_ready;
  logic           dp_valid;
  logic [CW-1:0]  dp_chan;
  logic [M-1:0]   dp_data;
  logic           dp_dump;
  logic           dp_ready;
  logic [RW-1:0]  rate_q;
  logic           busy;
  logic           cfg_err;

  logic [M-1:0] dat [NCH];

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign in_data = {dat[3], dat[2], dat[1], dat[0]};

  cic_channel_scheduler #(
    .NCH (NCH),
    .M   (M),
    .R   (4),
    .RW  (RW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_rate (cfg_rate),
    .cfg_load (cfg_load),
    .start    (start),
    .stop     (stop),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .dp_valid (dp_valid),
    .dp_chan  (dp_chan),
    .dp_data  (dp_data),
    .dp_dump  (dp_dump),
    .dp_ready (dp_ready),
    .rate_q   (rate_q),
    .busy     (busy),
    .cfg_err  (cfg_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v,
                       input logic       r,
                       input logic       st,
                       input logic       sp,
                       input logic       ld,
                       input logic [7:0] rt);
    @(negedge clk);
    in_valid = v;
    dp_ready = r;
    start    = st;
    stop     = sp;
    cfg_load = ld;
    cfg_rate = rt;
    #1;
  endtask

  task automatic chk_dp(input string tag,
                        input int ch,
                        input logic [15:0] d,
                        input logic dm);
    chk({tag, "_v"}, 32'(dp_valid), 32'd1);
    chk({tag, "_ch"}, 32'(dp_chan), 32'(ch));
    chk({tag, "_d"}, 32'(dp_data), 32'(d));
    chk({tag, "_dump"}, 32'(dp_dump), 32'(dm));
  endtask

  initial begin
    int n;
    int ch;
    logic [3:0] er;
    rst = 1'b1;
    in_valid = '0; dp_ready = 1'b0; start = 1'b0;
    stop = 1'b0; cfg_load = 1'b0; cfg_rate = '0;
    for (int c = 0; c < NCH; c++) dat[c] = 16'h00A0 + 16'(c);

    // reset state
    drive(4'h0, 0, 0, 0, 0, 0);
    drive(4'hF, 0, 0, 0, 0, 0);
    chk("rst_valid", 32'(dp_valid), 0);
    chk("rst_chan", 32'(dp_chan), 0);
    chk("rst_data", 32'(dp_data), 0);
    chk("rst_dump", 32'(dp_dump), 0);
    chk("rst_rdy", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(cfg_err), 0);
    chk("rst_rate", 32'(rate_q), 4);
    rst = 1'b0;

    // 1: all channels, full throughput, rate 4
    drive(4'h0, 1, 1, 0, 0, 0);
    for (int k = 0; k < 18; k++) begin
      drive((k < 16) ? 4'hF : 4'h0, 1, 0, 0, 0, 0);
      if (k == 0) chk("t1_busy", 32'(busy), 1);
      er = (k < 16) ? 4'(1 << (k % 4)) : 4'h0;
      chk("t1_rdy", 32'(in_ready), 32'(er));
      if (k >= 1 && k <= 16)
        chk_dp("t1", (k-1) % 4, 16'h00A0 + 16'((k-1) % 4), (k-1) >= 12);
      if (k == 17) chk("t1_idle_v", 32'(dp_valid), 0);
    end

    // 2: channels 1 and 3, dp_ready toggling, data scoreboard
    dat[0] = 16'h0; dat[2] = 16'h0;
    dat[1] = 16'h1000; dat[3] = 16'h3000;
    for (int j = 0; j < 18; j++) begin
      drive((j < 16) ? 4'b1010 : 4'b0000, (j % 2) == 0, 0, 0, 0, 0);
      er = 4'h0;
      if (j < 16 && (j % 2) == 0)
        er = ((j/2) % 2 == 0) ? 4'b0010 : 4'b1000;
      chk("t2_rdy", 32'(in_ready), 32'(er));
      if (j >= 1 && j <= 16) begin
        n  = (j-1) / 2;
        ch = (n % 2 == 1) ? 3 : 1;
        chk_dp("t2", ch, ((ch == 1) ? 16'h1000 : 16'h3000) + 16'(n/2),
               (n/2) == 3);
      end
      if (j == 17) chk("t2_idle_v", 32'(dp_valid), 0);
      if (j < 16 && (j % 2) == 0) begin
        ch = ((j/2) % 2 == 1) ? 3 : 1;
        @(posedge clk); #1;
        dat[ch] = dat[ch] + 16'd1;
      end
    end

    // 3: rate 3, partial frames, zero flush
    drive(4'h0, 1, 0, 1, 0, 0);
    chk("t3_run_busy", 32'(busy), 1);
    drive(4'hF, 1, 0, 0, 0, 0);
    chk("t3_fl_busy", 32'(busy), 1);
    chk("t3_fl_rdy", 32'(in_ready), 0);
    drive(4'h0, 1, 1, 0, 1, 3);
    chk("t3_idle", 32'(busy), 0);
    drive(4'h0, 1, 0, 0, 0, 0);
    chk("t3_rate", 32'(rate_q), 3);
    chk("t3_busy", 32'(busy), 1);
    chk("t3_err", 32'(cfg_err), 0);
    dat[0] = 16'h00C0; dat[2] = 16'h02C0;
    drive(4'b0100, 1, 0, 0, 0, 0);
    chk("t3_rdy0", 32'(in_ready), 32'b0100);
    @(posedge clk); #1;
    dat[2] = 16'h02C1;
    drive(4'b0101, 1, 0, 0, 0, 0);
    chk("t3_rdy1", 32'(in_ready), 32'b0001);
    chk_dp("t3_c1", 2, 16'h02C0, 0);
    drive(4'b0100, 1, 0, 1, 0, 0);
    chk("t3_rdy2", 32'(in_ready), 32'b0100);
    chk_dp("t3_c2", 0, 16'h00C0, 0);
    drive(4'hF, 1, 0, 0, 0, 0);
    chk("t3_rdy3", 32'(in_ready), 0);
    chk_dp("t3_c3", 2, 16'h02C1, 0);
    drive(4'hF, 1, 0, 0, 0, 0);
    chk_dp("t3_f1", 0, 16'h0, 0);
    drive(4'hF, 1, 0, 0, 0, 0);
    chk_dp("t3_f2", 2, 16'h0, 1);
    drive(4'hF, 1, 0, 0, 0, 0);
    chk_dp("t3_f3", 0, 16'h0, 1);
    chk("t3_f3_busy", 32'(busy), 1);
    drive(4'h0, 1, 0, 0, 0, 0);
    chk("t3_done_busy", 32'(busy), 0);
    chk("t3_done_v", 32'(dp_valid), 0);

    // 4: rejected config loads
    drive(4'h0, 1, 0, 0, 1, 0);
    chk("t4_err_pre", 32'(cfg_err), 0);
    drive(4'h0, 1, 0, 0, 0, 0);
    chk("t4_err_zero", 32'(cfg_err), 1);
    chk("t4_rate_zero", 32'(rate_q), 3);
    drive(4'h0, 1, 1, 0, 0, 0);
    chk("t4_err_clr", 32'(cfg_err), 0);
    drive(4'h0, 1, 0, 0, 1, 5);
    chk("t4_busy", 32'(busy), 1);
    drive(4'h0, 1, 0, 1, 0, 0);
    chk("t4_err_run", 32'(cfg_err), 1);
    chk("t4_rate_run", 32'(rate_q), 3);
    drive(4'h0, 1, 0, 0, 0, 0);
    chk("t4_err_clr2", 32'(cfg_err), 0);
    chk("t4_fl_busy", 32'(busy), 1);

    // 5: rate 1, every sample dumps, stop with no flush issues
    for (int c = 0; c < NCH; c++) dat[c] = 16'h5000 + 16'(c);
    drive(4'h0, 1, 1, 0, 1, 1);
    chk("t5_idle", 32'(busy), 0);
    chk("t5_rate_old", 32'(rate_q), 3);
    for (int k = 0; k < 5; k++) begin
      drive((k < 4) ? 4'hF : 4'h0, 1, 0, k == 4, 0, 0);
      if (k == 0) chk("t5_rate", 32'(rate_q), 1);
      er = (k < 4) ? 4'(1 << ((k + 1) % 4)) : 4'h0;
      chk("t5_rdy", 32'(in_ready), 32'(er));
      if (k >= 1)
        chk_dp("t5", k % 4, 16'h5000 + 16'(k % 4), 1);
    end
    drive(4'h0, 1, 0, 0, 0, 0);
    chk("t5_fl_v", 32'(dp_valid), 0);
    chk("t5_fl_busy", 32'(busy), 1);
    drive(4'h0, 1, 0, 0, 0, 0);
    chk("t5_idle_busy", 32'(busy), 0);
    chk("t5_idle_v", 32'(dp_valid), 0);

    // 6: reset while a flush issue is stalled
    dat[0] = 16'h0600;
    drive(4'h0, 1, 1, 0, 1, 2);
    drive(4'b0001, 1, 0, 0, 0, 0);
    chk("t6_rate", 32'(rate_q), 2);
    chk("t6_rdy", 32'(in_ready), 32'b0001);
    drive(4'h0, 0, 0, 1, 0, 0);
    chk_dp("t6_run", 0, 16'h0600, 0);
    drive(4'hF, 0, 0, 0, 0, 0);
    chk("t6_fl_v", 32'(dp_valid), 1);
    chk("t6_fl_busy", 32'(busy), 1);
    chk("t6_fl_rdy", 32'(in_ready), 0);
    rst = 1'b1;
    drive(4'h0, 0, 0, 0, 0, 0);
    chk("t6_rst_v", 32'(dp_valid), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_rate", 32'(rate_q), 4);
    rst = 1'b0;
    drive(4'h0, 1, 0, 1, 0, 0);
    drive(4'h0, 1, 1, 0, 0, 0);
    chk("t6_stop_ign", 32'(busy), 0);
    drive(4'hF, 1, 0, 0, 0, 0);
    chk("t6_ptr0", 32'(in_ready), 32'b0001);
    for (int k = 1; k < 5; k++) begin
      drive((k < 4) ? 4'b0001 : 4'b0000, 1, 0, k == 4, 0, 0);
      chk_dp("t6_ph", 0, 16'h0600, k == 4);
    end
    drive(4'h0, 1, 0, 0, 0, 0);
    drive(4'h0, 1, 0, 0, 0, 0);
    chk("t6_end_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
